// File: rtl/data.sv
`default_nettype none
// ============================================================================
// Module      : data
// Description : 8x8 Game-of-Life board (B3/S23, dead borders) with load,
//               run and hold modes; one generation per clock while running.
// Revision    : 1.0 - initial release
// ============================================================================
module data (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Grid,
    input  logic [1:0]  a,
    output logic [63:0] Grid_Evolved
);

    localparam logic [1:0] c_MODE_LOAD = 2'b01;
    localparam logic [1:0] c_MODE_RUN  = 2'b10;

    logic [63:0]      r_board;
    logic [63:0]      w_next;
    logic [9:0][9:0]  w_pad;

    // Board framed by a ring of permanently dead cells so every interior
    // cell sees exactly eight neighbour positions without wrap-around.
    always_comb begin
        w_pad = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                w_pad[r+1][c+1] = r_board[8*r+c];
            end
        end
    end

    for (genvar gr = 0; gr < 8; gr++) begin : g_row
        for (genvar gc = 0; gc < 8; gc++) begin : g_col
            logic [3:0] w_count;

            assign w_count = {3'b000, w_pad[gr  ][gc  ]} + {3'b000, w_pad[gr  ][gc+1]}
                           + {3'b000, w_pad[gr  ][gc+2]} + {3'b000, w_pad[gr+1][gc  ]}
                           + {3'b000, w_pad[gr+1][gc+2]} + {3'b000, w_pad[gr+2][gc  ]}
                           + {3'b000, w_pad[gr+2][gc+1]} + {3'b000, w_pad[gr+2][gc+2]};

            assign w_next[8*gr+gc] = (w_count == 4'd3) ||
                                     (r_board[8*gr+gc] && (w_count == 4'd2));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_board <= Grid;
        end else begin
            case (a)
                c_MODE_LOAD: r_board <= Grid;
                c_MODE_RUN:  r_board <= w_next;
                default:     r_board <= r_board;
            endcase
        end
    end

    assign Grid_Evolved = r_board;

endmodule
`default_nettype wire

// File: tb/tb_data.sv
`default_nettype none
// ============================================================================
// Module      : tb_data
// Description : Self-checking bench for data: directed Game-of-Life vectors
//               with a cell-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data;

    logic        clk;
    logic        reset;
    logic [63:0] Grid;
    logic [1:0]  a;
    logic [63:0] Grid_Evolved;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] m_board;
    logic        m_valid = 1'b0;

    data dut (
        .clk          (clk),
        .reset        (reset),
        .Grid         (Grid),
        .a            (a),
        .Grid_Evolved (Grid_Evolved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic alive(input logic [63:0] b, input int r, input int c);
        if (r < 0 || r > 7 || c < 0 || c > 7) return 1'b0;
        return b[8*r+c];
    endfunction

    function automatic logic [63:0] life_step(input logic [63:0] b);
        logic [63:0] n;
        int          k;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && alive(b, r+dr, c+dc)) k++;
                n[8*r+c] = (k == 3) || (b[8*r+c] && k == 2);
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: behaviour of the board as a whole per clock edge.
    always @(posedge clk) begin
        if (reset) begin
            m_board = Grid;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (a == 2'b01)      m_board = Grid;
            else if (a == 2'b10) m_board = life_step(m_board);
        end
    end

    always @(negedge clk) begin
        if (m_valid) check("model", Grid_Evolved, m_board);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Blinker
        reset = 1'b1; a = 2'b10; Grid = 64'h0000_0000_1C00_0000;
        tick();
        check("reset_seed", Grid_Evolved, 64'h0000_0000_1C00_0000);
        reset = 1'b0;
        tick();
        check("blinker_g1", Grid_Evolved, 64'h0000_0008_0808_0000);
        tick();
        check("blinker_g2", Grid_Evolved, 64'h0000_0000_1C00_0000);
        tick();
        check("blinker_g3", Grid_Evolved, 64'h0000_0008_0808_0000);

        // Hold with Grid wiggling: no effect
        a = 2'b00;
        for (int i = 0; i < 3; i++) begin
            Grid = 64'hDEAD_BEEF_0000_0000 ^ 64'(i);
            tick();
            check("hold00", Grid_Evolved, 64'h0000_0008_0808_0000);
        end

        a = 2'b01; Grid = 64'h0412_6424_0034_3C28;
        tick();
        check("load", Grid_Evolved, 64'h0412_6424_0034_3C28);

        a = 2'b11; Grid = 64'hFFFF_0000_FFFF_0000;
        tick();
        check("hold11", Grid_Evolved, 64'h0412_6424_0034_3C28);

        // Still life block; seed held after reset until run selected
        reset = 1'b1; a = 2'b00; Grid = 64'h0000_0000_0000_0303;
        tick();
        reset = 1'b0; Grid = 64'h0;
        tick();
        check("post_reset_hold", Grid_Evolved, 64'h0000_0000_0000_0303);
        a = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("still_life", Grid_Evolved, 64'h0000_0000_0000_0303);
        end

        // Full board: only corners survive, then extinction persists
        reset = 1'b1; Grid = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        reset = 1'b0;
        tick();
        check("full_g1", Grid_Evolved, 64'h8100_0000_0000_0081);
        tick();
        check("full_g2", Grid_Evolved, 64'h0);
        tick();
        check("empty_stays", Grid_Evolved, 64'h0);

        // Reset priority while running
        a = 2'b01; Grid = 64'h0412_6424_0034_3C28;
        tick();
        a = 2'b10;
        tick();
        tick();
        reset = 1'b1; Grid = 64'h0000_0000_0000_0001;
        tick();
        check("reset_prio", Grid_Evolved, 64'h1);
        reset = 1'b0;
        tick();
        check("lone_dies", Grid_Evolved, 64'h0);

        // Reset beats load too
        reset = 1'b1; a = 2'b01; Grid = 64'h0000_0000_0000_0303;
        tick();
        check("reset_over_load", Grid_Evolved, 64'h0000_0000_0000_0303);
        reset = 1'b0; a = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
